// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage sequencer for MULT/MULTU/DIV/DIVU.
// Owns a MUL_LAT-cycle multiplier and a 1-bit-per-cycle restoring divider.
// It raises stall_mul_o/stall_div_o towards the hazard unit while an
// operation runs. It holds HI/LO in DONE until the pipeline lets the
// instruction leave E, so an operation is never issued twice.
//
// Optional feature, selected by the macro MULDIV_DIV0_FAST_EN:
//   when defined, DIV/DIVU with a zero divisor skips the iterations and
//   goes IDLE->DONE directly. The result is bit-exact with what the full
//   divider produces.
//   when undefined, a zero divisor runs all WIDTH iterations.

module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic             pipe_stall_i,
  output logic             stall_div_o,
  output logic             stall_mul_o,
  output logic             result_vld_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Iteration counter, shared by the multiply delay and the divide loop.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Multiplicand, or the dividend/quotient shift register while dividing.
  logic [WIDTH-1:0] aReg_q, aReg_d;
  // Multiplier, or the divisor magnitude while dividing.
  logic [WIDTH-1:0] bReg_q, bReg_d;
  // Partial remainder of the restoring divider.
  logic [WIDTH-1:0] rem_q, rem_d;
  // Signedness and sign-fix flags captured at accept.
  logic             mulSigned_q, mulSigned_d;
  logic             quotNeg_q, quotNeg_d;
  logic             remNeg_q, remNeg_d;
  // Architectural HI/LO result registers.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic             signedDiv;
  logic             fastDiv0;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   partial;
  logic             take;
  logic [WIDTH-1:0] remStep;
  logic [WIDTH-1:0] quotStep;
  logic [2*WIDTH-1:0] aExt;
  logic [2*WIDTH-1:0] bExt;
  logic [2*WIDTH-1:0] product;

  // A new op is taken only from IDLE, never while flushing or in reset.
  assign accept    = resetn && (state_q == S_IDLE) && start_i && !cancel_i;
  assign signedDiv = (op_i == 2'b10);

  // The divider works on magnitudes. Signed DIV folds operand signs away here.
  assign absA = (signedDiv && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign absB = (signedDiv && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

`ifdef MULDIV_DIV0_FAST_EN
  assign fastDiv0 = op_i[1] && (b_i == '0);
`else
  assign fastDiv0 = 1'b0;
`endif

  // One restoring-division step: shift in the next dividend bit, then subtract if it fits.
  always_comb begin
    partial  = {rem_q, aReg_q[WIDTH-1]};
    take     = (partial >= {1'b0, bReg_q});
    remStep  = take ? (partial[WIDTH-1:0] - bReg_q) : partial[WIDTH-1:0];
    quotStep = {aReg_q[WIDTH-2:0], take};
  end

  // Full-width product; sign-extending both factors makes the low 2*WIDTH bits signed-correct.
  always_comb begin
    aExt    = mulSigned_q ? {{WIDTH{aReg_q[WIDTH-1]}}, aReg_q} : {{WIDTH{1'b0}}, aReg_q};
    bExt    = mulSigned_q ? {{WIDTH{bReg_q[WIDTH-1]}}, bReg_q} : {{WIDTH{1'b0}}, bReg_q};
    product = aExt * bExt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (cancel_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!op_i[1]) begin
              state_d = S_MUL;
            end else if (fastDiv0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (!pipe_stall_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs. The stalls cover the accept cycle combinationally. A flush masks them at once.
  always_comb begin
    stall_mul_o  = !cancel_i && ((accept && !op_i[1]) || (state_q == S_MUL));
    stall_div_o  = !cancel_i && ((accept &&  op_i[1]) || (state_q == S_DIV));
    result_vld_o = !cancel_i && (state_q == S_DONE);
    busy_o       = (state_q != S_IDLE);
    hi_o         = hi_q;
    lo_o         = lo_q;
  end

  // Working registers: load on accept, then step the counter and divider.
  always_comb begin
    cnt_d       = cnt_q;
    aReg_d      = aReg_q;
    bReg_d      = bReg_q;
    rem_d       = rem_q;
    mulSigned_d = mulSigned_q;
    quotNeg_d   = quotNeg_q;
    remNeg_d    = remNeg_q;
    if (accept) begin
      cnt_d       = op_i[1] ? CNT_W'(WIDTH - 1) : CNT_W'(MUL_LAT - 1);
      aReg_d      = absA;
      bReg_d      = absB;
      rem_d       = '0;
      mulSigned_d = (op_i == 2'b00);
      quotNeg_d   = signedDiv && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      remNeg_d    = signedDiv && a_i[WIDTH-1];
    end else if (state_q == S_DIV) begin
      rem_d  = remStep;
      aReg_d = quotStep;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (state_q == S_MUL) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // HI/LO change only on the transition into DONE, and never on a flush.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!cancel_i) begin
      case (state_q)
        S_IDLE: begin
`ifdef MULDIV_DIV0_FAST_EN
          if (accept && fastDiv0) begin
            hi_d = a_i;
            lo_d = (signedDiv && a_i[WIDTH-1]) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
          end
`endif
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            {hi_d, lo_d} = product;
          end
        end
        S_DIV: begin
          if (cnt_q == '0) begin
            hi_d = remNeg_q  ? (~remStep + 1'b1)  : remStep;
            lo_d = quotNeg_q ? (~quotStep + 1'b1) : quotStep;
          end
        end
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end
  end

  // Datapath and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q       <= '0;
      aReg_q      <= '0;
      bReg_q      <= '0;
      rem_q       <= '0;
      mulSigned_q <= 1'b0;
      quotNeg_q   <= 1'b0;
      remNeg_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      aReg_q      <= aReg_d;
      bReg_q      <= bReg_d;
      rem_q       <= rem_d;
      mulSigned_q <= mulSigned_d;
      quotNeg_q   <= quotNeg_d;
      remNeg_q    <= remNeg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl (WIDTH=32, MUL_LAT=2).
// The bench uses a table of directed vectors and randomized operations.
// Both are checked against an arithmetic reference model.
// Hand-written sequences cover flush, reset and stall corner cases.

module tb_muldiv_ctrl;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic             clk;
  logic             resetn;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             cancel;
  logic             pipeStall;
  logic             stallDiv;
  logic             stallMul;
  logic             resultVld;
  logic [WIDTH-1:0] hiOut;
  logic [WIDTH-1:0] loOut;
  logic             busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[12];

  muldiv_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start),
    .op_i         (op),
    .a_i          (opA),
    .b_i          (opB),
    .cancel_i     (cancel),
    .pipe_stall_i (pipeStall),
    .stall_div_o  (stallDiv),
    .stall_mul_o  (stallMul),
    .result_vld_o (resultVld),
    .hi_o         (hiOut),
    .lo_o         (loOut),
    .busy_o       (busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result {hi,lo} computed with plain integer arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) begin
          res = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else        res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Cycle index at which DONE is expected, counting the accept cycle as 0.
  function automatic int expLatency(input logic [1:0] o, input logic [31:0] b);
    if (!o[1]) return MUL_LAT + 1;
`ifdef MULDIV_DIV0_FAST_EN
    if (b == 0) return 1;
`endif
    return WIDTH + 1;
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Runs one operation end to end: timing, stall profile, result, and hold in DONE.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int hold, input logic [31:0] eHi, input logic [31:0] eLo);
    int   lat;
    int   c;
    int   stallErr;
    int   holdErr;
    bit   seen;
    logic isDiv;
    isDiv = o[1];
    lat = expLatency(o, b);
    @(posedge clk); #1;
    start = 1'b1; op = o; opA = a; opB = b;
    pipeStall = 1'($urandom_range(0, 1));
    c = 0; seen = 0; stallErr = 0;
    while (!seen && c <= lat + 8) begin
      @(negedge clk);
      if (resultVld) begin
        seen = 1;
      end else begin
        if (stallMul !== !isDiv || stallDiv !== isDiv || busy !== (c != 0)) stallErr++;
        @(posedge clk); #1;
        c++;
        pipeStall = (c >= lat) ? (hold > 0) : 1'($urandom_range(0, 1));
        opA = $urandom;
        opB = $urandom;
      end
    end
    checkOutput("latency", 64'(c), 64'(lat));
    checkOutput("stall_profile", 64'(stallErr), 64'd0);
    holdErr = 0;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(posedge clk); #1;
        pipeStall = (h < hold);
      end
      if (h > 0 || !seen) @(negedge clk);
      if (h == 0) begin
        checkOutput("hi", 64'(hiOut), 64'(eHi));
        checkOutput("lo", 64'(loOut), 64'(eLo));
      end
      if (resultVld !== 1'b1 || stallMul !== 1'b0 || stallDiv !== 1'b0 || busy !== 1'b1) holdErr++;
      if (hiOut !== eHi || loOut !== eLo) holdErr++;
    end
    checkOutput("done_hold", 64'(holdErr), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; pipeStall = 1'b0;
    @(negedge clk);
    checkOutput("idle_after", {60'd0, busy, resultVld, stallMul, stallDiv}, 64'd0);
    lastHi = eHi;
    lastLo = eLo;
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    logic [63:0] ref64;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'd2,         0, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2]  = '{2'b11, 32'd100,       32'd7,         5, 32'd2,         32'd14};
    vecs[3]  = '{2'b10, 32'hFFFF_FFFB, 32'd0,         0, 32'hFFFF_FFFB, 32'h0000_0001};
    vecs[4]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,         2, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{2'b11, 32'd5,         32'd0,         0, 32'd5,         32'hFFFF_FFFF};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 0, 32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{2'b10, 32'd5,         32'd0,         3, 32'd5,         32'hFFFF_FFFF};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[11] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h0000_0001};

    resetn = 1'b0; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
    cancel = 1'b0; pipeStall = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    checkOutput("reset_hilo", {hiOut, loOut}, 64'd0);
    checkOutput("reset_flags", {60'd0, busy, resultVld, stallMul, stallDiv}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].expHi, vecs[i].expLo);
    end

    // Flush at DIV cycle 10: stalls drop at once, IDLE next cycle, HI/LO untouched.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; opA = 32'd1000; opB = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(negedge clk);
    checkOutput("cancel_same_cycle", {61'd0, stallDiv, stallMul, resultVld}, 64'd0);
    checkOutput("cancel_still_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("cancel_idle", 64'(busy), 64'd0);
    checkOutput("cancel_hilo", {hiOut, loOut}, {lastHi, lastLo});
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("cancel_no_late_done", {61'd0, busy, resultVld, stallDiv}, 64'd0);
    checkOutput("cancel_hilo_later", {hiOut, loOut}, {lastHi, lastLo});

    // Flush together with start in IDLE: flush wins.
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; op = 2'b00; opA = 32'd3; opB = 32'd4;
    @(negedge clk);
    checkOutput("cancel_vs_start_stall", {62'd0, stallMul, stallDiv}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    checkOutput("cancel_vs_start_idle", 64'(busy), 64'd0);

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; opA = 32'd50; opB = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    resetn = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("midreset_hilo", {hiOut, loOut}, 64'd0);
    checkOutput("midreset_flags", {60'd0, busy, resultVld, stallMul, stallDiv}, 64'd0);
    lastHi = '0; lastLo = '0;
    applyStimulus(2'b11, 32'd100, 32'd7, 0, 32'd2, 32'd14);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      case ($urandom_range(0, 5))
        0:       rB = 32'd0;
        1:       rB = 32'($urandom_range(1, 20));
        2:       rB = 32'hFFFF_FFFF;
        default: rB = $urandom;
      endcase
      ref64 = refModel(rOp, rA, rB);
      applyStimulus(rOp, rA, rB, int'($urandom_range(0, 3)), ref64[63:32], ref64[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
